// File: rtl/morphle_eval_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morphle_eval_seq_pkg
// Brief    : Dual-rail codes, sequencer states and lane-check helpers
// Revision : 1.0
// ============================================================================
package morphle_eval_seq_pkg;

    localparam int MAX_LANES = 16;
    localparam int DR_W      = 2 * MAX_LANES;

    localparam logic [1:0] C_VEMPTY   = 2'b00;
    localparam logic [1:0] C_V0       = 2'b01;
    localparam logic [1:0] C_V1       = 2'b10;
    localparam logic [1:0] C_VILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_MATCH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Vectors are zero-padded to DR_W; only the low n lanes are inspected.
    function automatic logic lanes_all_valid(input logic [DR_W-1:0] v, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n && (v[2*i +: 2] == C_VEMPTY || v[2*i +: 2] == C_VILLEGAL)) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic lanes_all_empty(input logic [DR_W-1:0] v, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n && v[2*i +: 2] != C_VEMPTY) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic lanes_any_illegal(input logic [DR_W-1:0] v, input int n);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n && v[2*i +: 2] == C_VILLEGAL) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morphle_eval_seq_dr_sync_detect.sv
`default_nettype none
// ============================================================================
// Module   : dr_sync_detect
// Brief    : 2-flop synchroniser for the array outputs plus two-sample
//            all-valid / all-empty detection and illegal-code detection
// Revision : 1.0
// ============================================================================
module dr_sync_detect
    import morphle_eval_seq_pkg::*;
#(
    parameter int OW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2*OW-1:0] arr_out,
    output logic [2*OW-1:0] sync_out,
    output logic            all_valid,
    output logic            all_empty,
    output logic            any_illegal
);

    logic [2*OW-1:0] meta_q, meta_d;
    logic [2*OW-1:0] sync_q, sync_d;
    logic            valid_prev_q, valid_prev_d;
    logic            empty_prev_q, empty_prev_d;
    logic            w_valid_now, w_empty_now, w_illegal_now;

    always_comb begin
        w_valid_now   = lanes_all_valid(DR_W'(sync_q), OW);
        w_empty_now   = lanes_all_empty(DR_W'(sync_q), OW);
        w_illegal_now = lanes_any_illegal(DR_W'(sync_q), OW);
        meta_d        = arr_out;
        sync_d        = meta_q;
        valid_prev_d  = w_valid_now;
        empty_prev_d  = w_empty_now;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q       <= '0;
            sync_q       <= '0;
            valid_prev_q <= 1'b0;
            empty_prev_q <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            valid_prev_q <= valid_prev_d;
            empty_prev_q <= empty_prev_d;
        end
    end

    assign sync_out    = sync_q;
    assign all_valid   = w_valid_now && valid_prev_q;
    assign all_empty   = w_empty_now && empty_prev_q;
    assign any_illegal = w_illegal_now;

endmodule
`default_nettype wire

// File: rtl/morphle_eval_seq.sv
`default_nettype none
// ============================================================================
// Module   : morphle_eval_seq
// Brief    : Synchronous sequencer running one evaluation cycle through a
//            self-timed Morphle cell array (inputs, match wave, drain, result)
// Revision : 1.0
// ============================================================================
module morphle_eval_seq
    import morphle_eval_seq_pkg::*;
#(
    parameter int IW        = 4,
    parameter int OW        = 2,
    parameter int RST_CYC   = 4,
    parameter int MATCH_CYC = 3,
    parameter int TMO       = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IW-1:0]   cmd_data,
    input  logic [OW-1:0]   cmd_match,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [OW-1:0]   rsp_data,
    output logic            rsp_err,
    output logic            cell_reset,
    output logic [2*IW-1:0] arr_in,
    output logic [2*OW-1:0] arr_match,
    input  logic [2*OW-1:0] arr_out
);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [IW-1:0]   cmd_data_q, cmd_data_d;
    logic [OW-1:0]   cmd_match_q, cmd_match_d;
    logic [OW-1:0]   rsp_data_q, rsp_data_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic            cell_reset_q, cell_reset_d;
    logic [2*IW-1:0] arr_in_q, arr_in_d;
    logic [2*OW-1:0] arr_match_q, arr_match_d;

    logic [2*OW-1:0] w_sync;
    logic            w_all_valid, w_all_empty, w_any_illegal;
    logic            w_fault;

    dr_sync_detect #(.OW(OW)) u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .arr_out     (arr_out),
        .sync_out    (w_sync),
        .all_valid   (w_all_valid),
        .all_empty   (w_all_empty),
        .any_illegal (w_any_illegal)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 8'd1;
        err_d       = err_q;
        cmd_data_d  = cmd_data_q;
        cmd_match_d = cmd_match_q;
        rsp_data_d  = rsp_data_q;
        w_fault     = 1'b0;

        case (state_q)
            ST_CLR: begin
                if (cnt_q == 8'(RST_CYC - 1)) begin
                    state_d = err_q ? ST_RESP : ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_data_d  = cmd_data;
                    cmd_match_d = cmd_match;
                    state_d     = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (w_any_illegal) begin
                    w_fault = 1'b1;
                end else if (w_all_valid) begin
                    for (int i = 0; i < OW; i++) rsp_data_d[i] = (w_sync[2*i +: 2] == C_V1);
                    cnt_d   = '0;
                    state_d = ST_MATCH;
                end else if (cnt_q == 8'(TMO - 1)) begin
                    w_fault = 1'b1;
                end
            end
            ST_MATCH: begin
                if (cnt_q == 8'(MATCH_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_any_illegal) begin
                    w_fault = 1'b1;
                end else if (w_all_empty) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (cnt_q == 8'(TMO - 1)) begin
                    w_fault = 1'b1;
                end
            end
            ST_RESP: begin
                cnt_d = '0;
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_CLR;
            end
        endcase

        // Timeout and illegal codes share one recovery path: clear the array, then report.
        if (w_fault) begin
            err_d      = 1'b1;
            rsp_data_d = '0;
            cnt_d      = '0;
            state_d    = ST_CLR;
        end

        cmd_ready_d  = (state_d == ST_IDLE);
        rsp_valid_d  = (state_d == ST_RESP);
        rsp_err_d    = (state_d == ST_RESP) && err_d;
        cell_reset_d = (state_d == ST_CLR);

        arr_in_d = '0;
        if (state_d == ST_EVAL || state_d == ST_MATCH) begin
            for (int i = 0; i < IW; i++) arr_in_d[2*i +: 2] = cmd_data_d[i] ? C_V1 : C_V0;
        end

        arr_match_d = '0;
        if (state_d == ST_MATCH) begin
            for (int i = 0; i < OW; i++) arr_match_d[2*i +: 2] = cmd_match_d[i] ? C_V1 : C_V0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CLR;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            cmd_data_q   <= '0;
            cmd_match_q  <= '0;
            rsp_data_q   <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            cell_reset_q <= 1'b1;
            arr_in_q     <= '0;
            arr_match_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            cmd_data_q   <= cmd_data_d;
            cmd_match_q  <= cmd_match_d;
            rsp_data_q   <= rsp_data_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            cell_reset_q <= cell_reset_d;
            arr_in_q     <= arr_in_d;
            arr_match_q  <= arr_match_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign cell_reset = cell_reset_q;
    assign arr_in     = arr_in_q;
    assign arr_match  = arr_match_q;

endmodule
`default_nettype wire

// File: tb/tb_morphle_eval_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_morphle_eval_seq
// Brief    : Directed + randomized bench for morphle_eval_seq with a
//            delayed, return-to-empty array model
// Revision : 1.0
// ============================================================================
module tb_morphle_eval_seq;

    localparam int IW = 4;
    localparam int OW = 2;
    localparam int M_NORMAL  = 0;
    localparam int M_SILENT  = 1;
    localparam int M_ILLEGAL = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cmd_valid, cmd_ready;
    logic [IW-1:0]   cmd_data;
    logic [OW-1:0]   cmd_match;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [OW-1:0]   rsp_data;
    logic            cell_reset;
    logic [2*IW-1:0] arr_in;
    logic [2*OW-1:0] arr_match;
    logic [2*OW-1:0] arr_out;

    int n_cmp = 0;
    int n_err = 0;
    int model_mode = M_NORMAL;
    int max_delay  = 0;

    always #5 clk = ~clk;

    morphle_eval_seq #(
        .IW(IW), .OW(OW), .RST_CYC(4), .MATCH_CYC(3), .TMO(255)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_match  (cmd_match),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .cell_reset (cell_reset),
        .arr_in     (arr_in),
        .arr_match  (arr_match),
        .arr_out    (arr_out)
    );

    // Array function: out[1] = in[1] & in[3], out[0] = in[0] | in[2].
    function automatic logic [1:0] ref_f(input logic [3:0] d);
        return {d[1] & d[3], d[0] | d[2]};
    endfunction

    // Dual-rail encoding as arithmetic: lane i contributes (bit ? 2 : 1) * 4^i.
    function automatic logic [7:0] ref_dual4(input logic [3:0] d);
        int v;
        v = 0;
        for (int i = 0; i < 4; i++) v += (d[i] ? 2 : 1) * (4 ** i);
        return 8'(v);
    endfunction

    function automatic logic [3:0] ref_dual2(input logic [1:0] d);
        int v;
        v = 0;
        for (int i = 0; i < 2; i++) v += (d[i] ? 2 : 1) * (4 ** i);
        return 4'(v);
    endfunction

    function automatic logic [3:0] model_target(input logic [7:0] ain, input logic [3:0] cur);
        logic [3:0] b;
        logic [3:0] t;
        bit full, empty;
        full = 1; empty = 1;
        for (int i = 0; i < 4; i++) begin
            b[i] = (ain[2*i +: 2] == 2'b10);
            if (ain[2*i +: 2] == 2'b00) full = 0; else empty = 0;
        end
        if (model_mode == M_SILENT || empty) return 4'h0;
        if (!full) return cur;
        t = ref_dual2(ref_f(b));
        if (model_mode == M_ILLEGAL) t[1:0] = 2'b11;
        return t;
    endfunction

    // Array model: follows arr_in after a random delay, cleared by cell_reset.
    initial begin
        int pend_cnt;
        logic [3:0] pend_val, want;
        arr_out  = '0;
        pend_cnt = 0;
        pend_val = '0;
        forever begin
            @(posedge clk);
            #2;
            want = model_target(arr_in, arr_out);
            if (cell_reset === 1'b1) begin
                arr_out  = '0;
                pend_val = '0;
                pend_cnt = 0;
            end else if (want === arr_out) begin
                pend_val = want;
            end else begin
                if (want !== pend_val) begin
                    pend_val = want;
                    pend_cnt = int'($urandom_range(0, max_delay));
                end
                if (pend_cnt == 0) arr_out = want;
                else pend_cnt--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [3:0] d, input logic [1:0] m, input logic exp_err,
                           input int exp_lat, input string tag,
                           output int first_clr, output int clr_cnt, output logic [7:0] first_in);
        logic [1:0] exp_data;
        logic [7:0] exp_in;
        logic [3:0] exp_mt;
        bit saw_in, saw_empty, saw_mt;
        int cyc;
        exp_data  = exp_err ? 2'b00 : ref_f(d);
        exp_in    = ref_dual4(d);
        exp_mt    = ref_dual2(m);
        saw_in    = 0;
        saw_empty = 0;
        saw_mt    = 0;
        first_clr = -1;
        clr_cnt   = 0;
        wait_ready(tag);
        cmd_data  = d;
        cmd_match = m;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        first_in  = arr_in;
        for (cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (arr_in === exp_in) saw_in = 1;
            if (saw_in && arr_in === 8'h00) saw_empty = 1;
            if (arr_match === exp_mt) saw_mt = 1;
            if (cell_reset === 1'b1) begin
                if (first_clr < 0) first_clr = cyc;
                clr_cnt++;
            end
            if (rsp_valid === 1'b1) break;
        end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_arr_in_drive"}, 32'(saw_in), 32'd1);
        check({tag, "_arr_in_empty"}, 32'(saw_empty), 32'd1);
        check({tag, "_arr_match"}, 32'(saw_mt), 32'(!exp_err));
        check({tag, "_cell_reset_seen"}, 32'(clr_cnt > 0), 32'(exp_err));
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int first_clr, clr_cnt, k, viol;
        logic [7:0] first_in;
        logic [3:0] d;
        logic [1:0] m;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_data  = '0;
        cmd_match = '0;

        repeat (3) @(negedge clk);
        check("rst_cell_reset", 32'(cell_reset), 32'd1);
        check("rst_arr_in", 32'(arr_in), 32'h00);
        check("rst_arr_match", 32'(arr_match), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);

        reset_n = 1'b1;
        #1;
        check("clr_hold_0", 32'(cell_reset), 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("clr_hold", 32'(cell_reset), 32'd1);
            check("clr_not_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        check("clr_release", 32'(cell_reset), 32'd0);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        model_mode = M_NORMAL;
        max_delay  = 0;
        run_cmd(4'b1010, 2'b01, 1'b0, 11, "basic", first_clr, clr_cnt, first_in);
        check("basic_arr_in_value", 32'(first_in), 32'h99);
        check("basic_rsp_data_value", 32'(rsp_data), 32'h2);
        finish_rsp("basic");

        max_delay = 10;
        for (int n = 0; n < 8; n++) begin
            d = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            run_cmd(d, m, 1'b0, -1, "rand", first_clr, clr_cnt, first_in);
            finish_rsp("rand");
        end

        d = 4'($urandom_range(0, 15));
        m = 2'($urandom_range(0, 3));
        run_cmd(d, m, 1'b0, -1, "bp", first_clr, clr_cnt, first_in);
        cmd_data  = ~d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'(ref_f(d)));
            check("bp_rsp_err", 32'(rsp_err), 32'd0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        check("bp_back_to_idle", 32'(cmd_ready), 32'd1);
        check("bp_no_early_accept", 32'(arr_in), 32'h00);

        model_mode = M_SILENT;
        run_cmd(4'($urandom_range(0, 15)), 2'b10, 1'b1, 259, "tmo", first_clr, clr_cnt, first_in);
        check("tmo_first_clr", 32'(first_clr), 32'd255);
        check("tmo_clr_len", 32'(clr_cnt), 32'd4);
        finish_rsp("tmo");

        model_mode = M_ILLEGAL;
        max_delay  = 3;
        run_cmd(4'($urandom_range(0, 15)), 2'b01, 1'b1, -1, "ill", first_clr, clr_cnt, first_in);
        check("ill_clr_len", 32'(clr_cnt), 32'd4);
        finish_rsp("ill");
        model_mode = M_NORMAL;
        run_cmd(4'b0110, 2'b11, 1'b0, -1, "post_ill", first_clr, clr_cnt, first_in);
        finish_rsp("post_ill");

        max_delay = 0;
        wait_ready("mid");
        cmd_data  = 4'b1101;
        cmd_match = 2'b10;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (arr_match === 4'h0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_reach_match", 32'(arr_match), 32'(ref_dual2(2'b10)));
        reset_n = 1'b0;
        #1;
        check("mid_arr_match", 32'(arr_match), 32'h0);
        check("mid_cell_reset", 32'(cell_reset), 32'd1);
        check("mid_arr_in", 32'(arr_in), 32'h00);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) viol++;
        end
        check("mid_no_rsp", 32'(viol), 32'd0);
        run_cmd(4'b0011, 2'b00, 1'b0, 11, "post_mid", first_clr, clr_cnt, first_in);
        finish_rsp("post_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
